// File: rtl/axis_argmax_20_if.sv
// AXI4-Stream bundle (32-bit data, last, valid/ready) shared by both sides of the argmax block.
interface axis_argmax_20_if;
  logic [31:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_argmax_20.sv
// Streaming argmax over one frame of float32 scores; emits {flags, index} then the max value bits.
module axis_argmax_20 #(
  parameter int unsigned N     = 20,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic              aclk,
  input  logic              aresetn,
  axis_argmax_20_if.slave   input_axis,
  axis_argmax_20_if.master  output_axis
);

  typedef enum logic [1:0] {
    ACCUM    = 2'd0,
    SEND_IDX = 2'd1,
    SEND_VAL = 2'd2
  } state_t;

  // Maps float32 bits onto an unsigned key whose order is the float total order.
  function automatic logic [31:0] ord_key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic [31:0]      max_val_q, max_val_d;
  logic             short_q, short_d;
  logic             notlast_q, notlast_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [31:0]      out_data_q, out_data_d;

  logic             in_hs_c;
  logic             out_hs_c;
  logic             last_slot_c;
  logic             frame_end_c;
  logic [15:0]      idx16_c;

  assign input_axis.tready  = in_ready_q;
  assign output_axis.tvalid = out_valid_q;
  assign output_axis.tlast  = out_last_q;
  assign output_axis.tdata  = out_data_q;

  assign in_hs_c     = input_axis.tvalid & in_ready_q;
  assign out_hs_c    = out_valid_q & output_axis.tready;
  assign last_slot_c = (count_q == IDX_W'(N - 1));
  assign frame_end_c = in_hs_c & (input_axis.tlast | last_slot_c);
  assign idx16_c     = 16'(max_idx_d);

  // Running maximum, element counter and frame-length flags.
  always_comb begin
    count_d   = count_q;
    max_idx_d = max_idx_q;
    max_val_d = max_val_q;
    short_d   = short_q;
    notlast_d = notlast_q;
    if (in_hs_c) begin
      if ((count_q == '0) || (ord_key(input_axis.tdata) > ord_key(max_val_q))) begin
        max_val_d = input_axis.tdata;
        max_idx_d = count_q;
      end
      if (frame_end_c) begin
        short_d   = input_axis.tlast & ~last_slot_c;
        notlast_d = ~input_axis.tlast & last_slot_c;
      end else begin
        count_d = count_q + IDX_W'(1);
      end
    end else if ((state_q == SEND_VAL) && out_hs_c) begin
      count_d   = '0;
      short_d   = 1'b0;
      notlast_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_q   <= '0;
      max_idx_q <= '0;
      max_val_q <= '0;
      short_q   <= 1'b0;
      notlast_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      max_idx_q <= max_idx_d;
      max_val_q <= max_val_d;
      short_q   <= short_d;
      notlast_q <= notlast_d;
    end
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ACCUM;
    else          state_q <= state_d;
  end

  // Next-state logic: accumulate until frame end, then send index word and value word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:    if (frame_end_c) state_d = SEND_IDX;
      SEND_IDX: if (out_hs_c)    state_d = SEND_VAL;
      SEND_VAL: if (out_hs_c)    state_d = ACCUM;
      default:                   state_d = ACCUM;
    endcase
  end

  // Output decode from the next state so outputs update on the same edge as the state.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_data_d  = '0;
    case (state_d)
      ACCUM: begin
        in_ready_d = 1'b1;
      end
      SEND_IDX: begin
        out_valid_d = 1'b1;
        out_data_d  = {short_d, notlast_d, 14'b0, idx16_c};
      end
      SEND_VAL: begin
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        out_data_d  = max_val_d;
      end
      default: begin
        in_ready_d = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs; all low while in reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_axis_argmax_20.sv
// Directed plus randomized bench for axis_argmax_20 with a queue-based argmax reference.
module tb_axis_argmax_20;
  localparam int unsigned N = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  axis_argmax_20_if in_if ();
  axis_argmax_20_if out_if ();

  axis_argmax_20 #(.N(N)) dut (
    .aclk        (clk),
    .aresetn     (rst_n),
    .input_axis  (in_if),
    .output_axis (out_if)
  );

  int unsigned npass  = 0;
  int unsigned ntotal = 0;

  logic [31:0] fq[$];
  bit          tl_final;
  int unsigned gap_pct;
  int unsigned s_first;
  logic [31:0] t1[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal = ntotal + 1;
    assert (obs === exp) npass = npass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] f32_of(input real r);
    logic s;
    real  a;
    int   e;
    int   m;
    s = (r < 0.0);
    a = s ? -r : r;
    if (a == 0.0) return {s, 31'b0};
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e = e + 1; end
    while (a < 1.0)  begin a = a * 2.0; e = e - 1; end
    m = $rtoi((a - 1.0) * 8388608.0 + 0.5);
    if (m >= 8388608) begin m = 0; e = e + 1; end
    return {s, 8'(e + 127), 23'(m)};
  endfunction

  // Random float with magnitude in [0.25, 4).
  function automatic logic [31:0] rnd_small();
    return {1'($urandom_range(0, 1)), 8'(8'h7D + $urandom_range(0, 3)), 23'($urandom)};
  endfunction

  function automatic logic [31:0] key_of(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  // Reference: largest key in the frame, then the earliest element holding it.
  task automatic model(output logic [31:0] w0, output logic [31:0] w1);
    logic [31:0] maxk;
    int          idx;
    bit          sflag, nflag;
    maxk = key_of(fq[0]);
    foreach (fq[i]) if (key_of(fq[i]) > maxk) maxk = key_of(fq[i]);
    idx = -1;
    foreach (fq[i]) if (idx < 0 && key_of(fq[i]) == maxk) idx = i;
    sflag = tl_final && (fq.size() < N);
    nflag = !tl_final && (fq.size() == N);
    w0 = {sflag, nflag, 14'b0, 16'(idx)};
    w1 = fq[idx];
  endtask

  task automatic send_frame();
    int unsigned acc;
    int unsigned n;
    int unsigned g;
    acc = 0;
    for (int i = 0; i < fq.size(); i++) begin
      g = 0;
      while (gap_pct > 0 && g < 5 && $urandom_range(0, 99) < gap_pct) begin
        @(negedge clk);
        in_if.tvalid = 1'b0;
        g++;
      end
      @(negedge clk);
      in_if.tvalid = 1'b1;
      in_if.tdata  = fq[i];
      in_if.tlast  = tl_final && (i == fq.size() - 1);
      n = 0;
      while (!in_if.tready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (i == 0) s_first = cyc;
      if (in_if.tready) acc++;
      @(posedge clk);
    end
    #1;
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    chk("send_accepted", 32'(acc), 32'(fq.size()));
  endtask

  task automatic recv(input int unsigned stall, output logic [31:0] w0, output logic [31:0] w1,
                      output logic l0, output logic l1, output int unsigned st1);
    int unsigned got;
    int unsigned n;
    logic [31:0] ref_data;
    got = 0;
    n = 0;
    w0 = '0; w1 = '0; l0 = 1'b0; l1 = 1'b0; st1 = 0;
    out_if.tready = (stall == 0);
    @(negedge clk);
    if (stall > 0) begin
      while (!out_if.tvalid && n < 200) begin
        @(negedge clk);
        n++;
      end
      ref_data = out_if.tdata;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        chk("stall_tvalid", 32'(out_if.tvalid), 32'd1);
        chk("stall_tdata", out_if.tdata, ref_data);
        chk("stall_in_tready", 32'(in_if.tready), 32'd0);
      end
      out_if.tready = 1'b1;
    end
    while (got < 2 && n < 500) begin
      if (out_if.tvalid && out_if.tready) begin
        if (got == 0) begin
          w0 = out_if.tdata; l0 = out_if.tlast;
        end else begin
          w1 = out_if.tdata; l1 = out_if.tlast; st1 = cyc;
        end
        got++;
      end
      if (got < 2) begin
        @(negedge clk);
        n++;
      end
    end
    @(posedge clk);
    #1;
    out_if.tready = 1'b0;
    chk("recv_words", 32'(got), 32'd2);
  endtask

  // Sends the frame in fq and checks both result words against the model.
  task automatic run_frame(input string tag, input int unsigned stall);
    logic [31:0] e0, e1, w0, w1;
    logic        l0, l1;
    int unsigned st1;
    model(e0, e1);
    send_frame();
    recv(stall, w0, w1, l0, l1, st1);
    chk({tag, "_w0"}, w0, e0);
    chk({tag, "_w1"}, w1, e1);
    chk({tag, "_l0"}, 32'(l0), 32'd0);
    chk({tag, "_l1"}, 32'(l1), 32'd1);
  endtask

  task automatic load_t1();
    fq.delete();
    foreach (t1[i]) fq.push_back(t1[i]);
    tl_final = 1'b1;
  endtask

  initial begin
    logic [31:0] w0, w1;
    logic        l0, l1;
    int unsigned st1;
    int unsigned len;

    rst_n         = 1'b0;
    in_if.tvalid  = 1'b0;
    in_if.tlast   = 1'b0;
    in_if.tdata   = '0;
    out_if.tready = 1'b0;
    gap_pct       = 0;
    tl_final      = 1'b1;

    foreach (t1[i]) t1[i] = rnd_small();
    t1[0]  = f32_of(3.3947);
    t1[1]  = f32_of(-4.1951);
    t1[12] = f32_of(4.7107839);
    t1[19] = f32_of(-2.3826);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_tvalid", 32'(out_if.tvalid), 32'd0);
    chk("rst_out_tlast", 32'(out_if.tlast), 32'd0);
    chk("rst_out_tdata", out_if.tdata, 32'd0);
    chk("rst_in_tready", 32'(in_if.tready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_tready", 32'(in_if.tready), 32'd1);

    // Test 1: reference frame, back-to-back, with latency check
    load_t1();
    out_if.tready = 1'b1;
    send_frame();
    recv(0, w0, w1, l0, l1, st1);
    chk("t1_w0", w0, 32'h0000_000C);
    chk("t1_l0", 32'(l0), 32'd0);
    chk("t1_w1", w1, f32_of(4.7107839));
    chk("t1_l1", 32'(l1), 32'd1);
    chk("t1_cycles", 32'(st1 - s_first + 1), 32'd22);
    @(negedge clk);
    chk("t1_in_tready_after", 32'(in_if.tready), 32'd1);

    // Test 2: all ties
    fq.delete();
    repeat (N) fq.push_back(32'h3F80_0000);
    tl_final = 1'b1;
    run_frame("t2", 0);

    // Test 3a: ascending negatives
    fq.delete();
    for (int i = 0; i < N; i++) fq.push_back(f32_of(-real'(N - i)));
    tl_final = 1'b1;
    run_frame("t3a", 0);
    chk("t3a_idx", 32'(fq.size()), 32'd20);
    begin
      logic [31:0] e0, e1;
      model(e0, e1);
      chk("t3a_model_w0", e0, 32'h0000_0013);
      chk("t3a_model_w1", e1, 32'hBF80_0000);
    end

    // Test 3b: -0.0 versus +0.0
    fq.delete();
    repeat (N) fq.push_back(32'hBF80_0000);
    fq[0] = 32'h8000_0000;
    fq[5] = 32'h0000_0000;
    tl_final = 1'b1;
    send_frame();
    recv(0, w0, w1, l0, l1, st1);
    chk("t3b_w0", w0, 32'h0000_0005);
    chk("t3b_w1", w1, 32'h0000_0000);

    // Test 4a: short frame
    fq.delete();
    fq.push_back(32'h3F80_0000);
    fq.push_back(32'hC040_0000);
    fq.push_back(32'h3FC0_0000);
    fq.push_back(32'h4000_0000);
    fq.push_back(32'hBF80_0000);
    tl_final = 1'b1;
    send_frame();
    recv(0, w0, w1, l0, l1, st1);
    chk("t4a_w0", w0, 32'h8000_0003);
    chk("t4a_w1", w1, 32'h4000_0000);

    // Test 4b: missing TLAST, then a normal frame right after
    fq.delete();
    repeat (N) fq.push_back($urandom);
    tl_final = 1'b0;
    run_frame("t4b", 0);
    load_t1();
    send_frame();
    recv(0, w0, w1, l0, l1, st1);
    chk("t4b_next_w0", w0, 32'h0000_000C);
    chk("t4b_next_w1", w1, t1[12]);

    // Test 5: output backpressure and input gaps
    load_t1();
    run_frame("t5_stall", 10);
    load_t1();
    gap_pct = 40;
    run_frame("t5_gaps", 0);
    gap_pct = 0;

    // Test 6a: reset during SEND_VAL
    load_t1();
    send_frame();
    @(negedge clk);
    out_if.tready = 1'b1;
    @(negedge clk);
    out_if.tready = 1'b0;
    chk("t6a_pre_tlast", 32'(out_if.tlast), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6a_tvalid_rst", 32'(out_if.tvalid), 32'd0);
    chk("t6a_in_tready_rst", 32'(in_if.tready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6a_no_stray", 32'(out_if.tvalid), 32'd0);
    end

    // Test 6b: reset mid-frame at word 7
    fq.delete();
    for (int i = 0; i < 7; i++) fq.push_back(32'h7F00_0000);
    tl_final = 1'b0;
    send_frame();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6b_in_tready_rst", 32'(in_if.tready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6b_no_stray", 32'(out_if.tvalid), 32'd0);
    end
    load_t1();
    send_frame();
    recv(0, w0, w1, l0, l1, st1);
    chk("t6b_w0", w0, 32'h0000_000C);
    chk("t6b_w1", w1, t1[12]);

    // Randomized frames: arbitrary bits, lengths, ties, gaps and stalls
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, N);
      fq.delete();
      for (int i = 0; i < len; i++) begin
        if (i > 0 && $urandom_range(0, 99) < 30) fq.push_back(fq[$urandom_range(0, i - 1)]);
        else fq.push_back($urandom);
      end
      tl_final = (len < N) ? 1'b1 : 1'($urandom_range(0, 1));
      gap_pct  = $urandom_range(0, 30);
      run_frame($sformatf("rnd%0d", r), $urandom_range(0, 3));
    end
    gap_pct = 0;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
